// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: arbiter states, slice phases and the
// request/tag records carried through the VRAM pipeline.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_BLIT_ONLY = 2'd0,
        ARB_DRAIN     = 2'd1,
        ARB_SHARED    = 2'd2
    } arb_state_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_VID_REQ  = 2'd0;
    localparam phase_t PH_BLIT_GNT = 2'd1;
    localparam phase_t PH_BLIT_REQ = 2'd2;
    localparam phase_t PH_BLIT_ACC = 2'd3;

    // Which requester owns the read that is currently on the VRAM bus.
    typedef struct packed {
        logic vid;
        logic blit;
    } rd_tag_t;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } vram_req_t;

endpackage

// File: rtl/vram_arb_if.sv
// Blitter, video and VRAM-macro signals of the arbiter, bundled as one interface.
interface vram_arb_if;
    logic        video_ena_i;
    logic        blit_cycle_o;
    logic        blit_sel_i;
    logic        blit_wr_i;
    logic [15:0] blit_addr_i;
    logic [15:0] blit_data_i;
    logic [15:0] blit_data_o;
    logic        blit_rd_valid_o;
    logic        blit_err_o;
    logic        vid_req_i;
    logic [15:0] vid_addr_i;
    logic [15:0] vid_data_o;
    logic        vid_valid_o;
    logic        vram_sel_o;
    logic        vram_wr_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [15:0] vram_data_i;

    modport master (
        input  video_ena_i, blit_sel_i, blit_wr_i, blit_addr_i, blit_data_i,
               vid_req_i, vid_addr_i, vram_data_i,
        output blit_cycle_o, blit_data_o, blit_rd_valid_o, blit_err_o,
               vid_data_o, vid_valid_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o
    );

    modport slave (
        output video_ena_i, blit_sel_i, blit_wr_i, blit_addr_i, blit_data_i,
               vid_req_i, vid_addr_i, vram_data_i,
        input  blit_cycle_o, blit_data_o, blit_rd_valid_o, blit_err_o,
               vid_data_o, vid_valid_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o
    );
endinterface

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: blitter owns every cycle while video is off,
// otherwise a fixed 4-phase slice alternates one video read and one blit access.
module vram_arb
    import vram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n_i,
    vram_arb_if.master bus
);

    arb_state_e  state_q, state_d;
    phase_t      ph_q, ph_d;
    logic        drain_q, drain_d;
    logic        blit_cycle_q, blit_cycle_d;
    logic        grant_q, grant_d;
    logic        err_q, err_d;
    vram_req_t   vram_q, vram_d;
    rd_tag_t     acc_q, acc_d;
    rd_tag_t     dat_q, dat_d;
    logic [15:0] blit_data_q, blit_data_d;
    logic [15:0] vid_data_q, vid_data_d;
    logic        blit_vld_q, blit_vld_d;
    logic        vid_vld_q, vid_vld_d;
    logic        accept, take_blit, take_vid;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        drain_d   = drain_q;
        grant_d   = blit_cycle_q;
        accept    = grant_q & bus.blit_sel_i;
        err_d     = err_q | (bus.blit_sel_i & ~grant_q);
        take_blit = 1'b0;
        take_vid  = 1'b0;

        unique case (state_q)
            ARB_BLIT_ONLY: begin
                take_blit = accept;
                if (bus.video_ena_i) begin
                    state_d = ARB_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ARB_DRAIN: begin
                // Two grant-free cycles let the last two requests reach VRAM.
                take_blit = accept;
                drain_d   = 1'b1;
                if (drain_q) begin
                    state_d = ARB_SHARED;
                    ph_d    = PH_VID_REQ;
                    drain_d = 1'b0;
                end
            end
            ARB_SHARED: begin
                ph_d      = ph_q + 2'd1;
                take_vid  = (ph_q == PH_VID_REQ) & bus.vid_req_i;
                take_blit = (ph_q == PH_BLIT_REQ) & accept;
                if (ph_q == PH_BLIT_ACC && !bus.video_ena_i) begin
                    state_d = ARB_BLIT_ONLY;
                    ph_d    = PH_VID_REQ;
                end
            end
            default: begin
                state_d = ARB_BLIT_ONLY;
                ph_d    = PH_VID_REQ;
            end
        endcase

        blit_cycle_d = (state_d == ARB_BLIT_ONLY) ||
                       (state_d == ARB_SHARED && ph_d == PH_BLIT_GNT);

        vram_d     = vram_q;
        vram_d.sel = 1'b0;
        vram_d.wr  = 1'b0;
        acc_d      = '0;
        if (take_vid) begin
            vram_d.sel  = 1'b1;
            vram_d.addr = bus.vid_addr_i;
            acc_d.vid   = 1'b1;
        end else if (take_blit) begin
            vram_d.sel  = 1'b1;
            vram_d.wr   = bus.blit_wr_i;
            vram_d.addr = bus.blit_addr_i;
            vram_d.data = bus.blit_data_i;
            acc_d.blit  = ~bus.blit_wr_i;
        end

        // Tag follows the access one cycle to line up with vram_data_i.
        dat_d       = acc_q;
        blit_vld_d  = dat_q.blit;
        vid_vld_d   = dat_q.vid;
        blit_data_d = dat_q.blit ? bus.vram_data_i : blit_data_q;
        vid_data_d  = dat_q.vid  ? bus.vram_data_i : vid_data_q;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ARB_BLIT_ONLY;
            ph_q         <= PH_VID_REQ;
            drain_q      <= 1'b0;
            blit_cycle_q <= 1'b0;
            grant_q      <= 1'b0;
            err_q        <= 1'b0;
            vram_q       <= '0;
            acc_q        <= '0;
            dat_q        <= '0;
            blit_data_q  <= '0;
            vid_data_q   <= '0;
            blit_vld_q   <= 1'b0;
            vid_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            drain_q      <= drain_d;
            blit_cycle_q <= blit_cycle_d;
            grant_q      <= grant_d;
            err_q        <= err_d;
            vram_q       <= vram_d;
            acc_q        <= acc_d;
            dat_q        <= dat_d;
            blit_data_q  <= blit_data_d;
            vid_data_q   <= vid_data_d;
            blit_vld_q   <= blit_vld_d;
            vid_vld_q    <= vid_vld_d;
        end
    end

    assign bus.blit_cycle_o    = blit_cycle_q;
    assign bus.blit_err_o      = err_q;
    assign bus.blit_data_o     = blit_data_q;
    assign bus.blit_rd_valid_o = blit_vld_q;
    assign bus.vid_data_o      = vid_data_q;
    assign bus.vid_valid_o     = vid_vld_q;
    assign bus.vram_sel_o      = vram_q.sel;
    assign bus.vram_wr_o       = vram_q.wr;
    assign bus.vram_addr_o     = vram_q.addr;
    assign bus.vram_data_o     = vram_q.data;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: directed phases with randomized traffic, checked against
// a cycle-count schedule model, an in-order access queue and a VRAM memory model.
module tb_vram_arb;

    typedef struct {
        int          due;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    logic clk = 1'b0;
    logic reset_n_i = 1'b0;
    vram_arb_if bus();

    vram_arb dut (.clk(clk), .reset_n_i(reset_n_i), .bus(bus));

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    bit [15:0] mdl_mem  [0:65535];
    bit [15:0] vram_mem [0:65535];
    acc_t accq[$];
    rd_t  brq[$];
    rd_t  vrq[$];
    op_t  ops[$];

    int   cyc, m_drain, m_base;
    bit   m_bo, m_sh, gnt_prev, gnt_now, exp_err;
    bit   rd_last, force_err;
    logic [15:0] rd_last_addr, wa;
    int   pol, vid_pol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_gnt",   32'(bus.blit_cycle_o),    0);
        chk("rst_sel",   32'(bus.vram_sel_o),      0);
        chk("rst_wr",    32'(bus.vram_wr_o),       0);
        chk("rst_addr",  32'(bus.vram_addr_o),     0);
        chk("rst_wdata", 32'(bus.vram_data_o),     0);
        chk("rst_bdata", 32'(bus.blit_data_o),     0);
        chk("rst_bvld",  32'(bus.blit_rd_valid_o), 0);
        chk("rst_err",   32'(bus.blit_err_o),      0);
        chk("rst_vdata", 32'(bus.vid_data_o),      0);
        chk("rst_vvld",  32'(bus.vid_valid_o),     0);
    endtask

    task automatic model_reset();
        m_bo = 1; m_sh = 0; m_drain = 0; m_base = 0;
        gnt_prev = 0; gnt_now = 0; exp_err = 0; cyc = 0;
        rd_last = 0; force_err = 0;
        accq.delete(); brq.delete(); vrq.delete();
        bus.blit_sel_i = 0; bus.blit_wr_i = 0; bus.vid_req_i = 0;
        bus.blit_addr_i = 0; bus.blit_data_i = 0; bus.vid_addr_i = 0;
        bus.vram_data_i = 0;
    endtask

    function automatic bit in_phase(input int c, input int p);
        return m_sh && (((c - m_base) & 3) == p);
    endfunction

    task automatic tick();
        acc_t e;
        rd_t  r;
        bit   ex;
        op_t  o;
        @(posedge clk); #1;
        cyc++;
        // Requests presented during the previous cycle.
        if (bus.blit_sel_i) begin
            if (gnt_prev) begin
                accq.push_back('{cyc, bus.blit_wr_i, bus.blit_addr_i, bus.blit_data_i});
                if (bus.blit_wr_i) mdl_mem[bus.blit_addr_i] = bus.blit_data_i;
                else brq.push_back('{cyc + 2, mdl_mem[bus.blit_addr_i]});
            end else begin
                exp_err = 1;
            end
        end
        if (in_phase(cyc - 1, 0) && bus.vid_req_i) begin
            accq.push_back('{cyc, 1'b0, bus.vid_addr_i, 16'h0});
            vrq.push_back('{cyc + 2, mdl_mem[bus.vid_addr_i]});
        end
        // Advance the schedule into this cycle.
        if (m_bo) begin
            if (bus.video_ena_i) begin m_bo = 0; m_drain = 2; end
        end else if (m_drain != 0) begin
            if (m_drain == 1) begin m_drain = 0; m_sh = 1; m_base = cyc; end
            else m_drain--;
        end else if (in_phase(cyc - 1, 3) && !bus.video_ena_i) begin
            m_sh = 0; m_bo = 1;
        end
        gnt_prev = gnt_now;
        gnt_now  = m_bo || in_phase(cyc, 1);

        chk("grant", 32'(bus.blit_cycle_o), 32'(gnt_now));
        chk("err",   32'(bus.blit_err_o),   32'(exp_err));
        ex = accq.size() != 0 && accq[0].due == cyc;
        if (ex) e = accq.pop_front();
        chk("vram_sel", 32'(bus.vram_sel_o), 32'(ex));
        if (ex && bus.vram_sel_o) begin
            chk("vram_wr",   32'(bus.vram_wr_o),   32'(e.wr));
            chk("vram_addr", 32'(bus.vram_addr_o), 32'(e.addr));
            if (e.wr) chk("vram_wdata", 32'(bus.vram_data_o), 32'(e.data));
        end
        ex = brq.size() != 0 && brq[0].due == cyc;
        if (ex) r = brq.pop_front();
        chk("blit_vld", 32'(bus.blit_rd_valid_o), 32'(ex));
        if (ex && bus.blit_rd_valid_o) chk("blit_rdata", 32'(bus.blit_data_o), 32'(r.data));
        ex = vrq.size() != 0 && vrq[0].due == cyc;
        if (ex) r = vrq.pop_front();
        chk("vid_vld", 32'(bus.vid_valid_o), 32'(ex));
        if (ex && bus.vid_valid_o) chk("vid_rdata", 32'(bus.vid_data_o), 32'(r.data));

        // VRAM macro behaviour: read data one cycle after the access.
        bus.vram_data_i = rd_last ? vram_mem[rd_last_addr] : 16'($urandom);
        rd_last      = bus.vram_sel_o && !bus.vram_wr_o;
        rd_last_addr = bus.vram_addr_o;
        if (bus.vram_sel_o && bus.vram_wr_o) vram_mem[bus.vram_addr_o] = bus.vram_data_o;

        // Blitter: request only in the cycle after a grant.
        bus.blit_sel_i  = 0;
        bus.blit_wr_i   = 0;
        bus.blit_addr_i = 16'($urandom);
        bus.blit_data_i = 16'($urandom);
        if (gnt_prev) begin
            case (pol)
                1: begin
                    bus.blit_sel_i = 1; bus.blit_wr_i = 1;
                    bus.blit_addr_i = wa; bus.blit_data_i = 16'h1F20; wa--;
                end
                2: if ($urandom_range(3) != 0) begin
                    bus.blit_sel_i  = 1;
                    bus.blit_wr_i   = 1'($urandom_range(1));
                    bus.blit_addr_i = 16'($urandom_range(63));
                end
                3: if (ops.size() != 0) begin
                    o = ops.pop_front();
                    bus.blit_sel_i = 1; bus.blit_wr_i = o.wr;
                    bus.blit_addr_i = o.addr; bus.blit_data_i = o.data;
                end
                default: ;
            endcase
        end else if (force_err) begin
            bus.blit_sel_i = 1; bus.blit_wr_i = 1; bus.blit_addr_i = 16'h0077;
            force_err = 0;
        end
        bus.vid_req_i  = (vid_pol == 1) || (vid_pol == 2 && $urandom_range(1) == 1);
        bus.vid_addr_i = (vid_pol == 1) ? 16'h0100 : 16'($urandom_range(63));
    endtask

    initial begin
        bit hit;
        bus.video_ena_i = 0;
        pol = 0; vid_pol = 0; wa = 16'hFFFF;
        model_reset();
        #3 chk_reset_outs();
        repeat (2) @(posedge clk);
        #2 reset_n_i = 1;

        // Blit-only write burst, descending addresses.
        pol = 1;
        repeat (20) tick();

        // Preload known words, then random blit-only traffic.
        ops.push_back('{1'b1, 16'h0100, 16'hABCD});
        ops.push_back('{1'b1, 16'h0050, 16'h1234});
        pol = 3;
        repeat (4) tick();
        pol = 2;
        repeat (30) tick();

        // Raise video enable in the middle of back-to-back writes.
        pol = 1;
        repeat (5) tick();
        bus.video_ena_i = 1;
        repeat (12) tick();

        // Shared: steady video reads of 0x0100, then a blit read of 0x0050.
        pol = 0; vid_pol = 1;
        repeat (16) tick();
        ops.push_back('{1'b0, 16'h0050, 16'h0000});
        pol = 3;
        repeat (12) tick();

        // Random shared traffic, exit to blit-only, and back.
        pol = 2; vid_pol = 2;
        repeat (60) tick();
        bus.video_ena_i = 0;
        repeat (20) tick();
        bus.video_ena_i = 1;
        repeat (20) tick();

        // Ungranted request sets the sticky error.
        force_err = 1;
        repeat (12) tick();
        chk("err_sticky", 32'(bus.blit_err_o), 1);

        // Asynchronous reset in ph2.
        hit = in_phase(cyc, 2);
        for (int i = 0; i < 8 && !hit; i++) begin
            tick();
            hit = in_phase(cyc, 2);
        end
        chk("reach_ph2", 32'(hit), 1);
        #2 reset_n_i = 0;
        #1 chk_reset_outs();
        bus.video_ena_i = 0;
        pol = 0; vid_pol = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n_i = 1;
        pol = 2;
        repeat (16) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
